charge_timer: RTL

Parametrised coin-operated charging countdown timer: the next-generation replacement for the fixed 1:59 charging-station counter. It accumulates credit from coin strobes into a BCD M…M:SS time and counts it down once per prescaled tick while charging, with saturation, cancel, a completion pulse and an optional pause. It sits between the coin acceptor and the display/relay driver.

---
 rtl/charge_timer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/charge_timer.sv
`default_nettype none
//==============================================================================
// Module      : charge_timer
// Description : Coin-operated charging countdown timer. Coin strobes build up
//               credit as a BCD M..M:SS time. While charging, the time counts
//               down once per prescaled tick. Credit saturates at the maximum,
//               Cancel aborts the session, and Done pulses at 0:00.
//               Optional feature macro: CHARGE_PAUSE_EN (Pause freezes the
//               countdown in a PAUSED state).
// Revision    : 1.0 - initial release
//==============================================================================
module charge_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                        Clk,
    input  logic                        nReset,
    input  logic                        CoinValid,
    input  logic [2:0]                  Coin,
    input  logic                        Cancel,
    input  logic                        Pause,
    output logic [4*(MIN_DIGITS+2)-1:0] PresentTime,
    output logic                        Charging,
    output logic                        Done,
    output logic                        Saturated
);

    // The time is held internally as binary seconds. The widest sum is the
    // maximum time plus the largest coin (300 s), so TW covers that sum.
    localparam int unsigned c_MAX_SECS = (10**MIN_DIGITS - 1) * 60 + 59;
    localparam int          TW         = $clog2(c_MAX_SECS + 301);
    localparam int          OW         = 4 * (MIN_DIGITS + 2);
    localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] c_MAX  = TW'(c_MAX_SECS);
    localparam logic [PW-1:0] c_TERM = PW'(TICK_DIV - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_CHARGING = 2'd1;
`ifdef CHARGE_PAUSE_EN
    localparam logic [1:0] c_PAUSED   = 2'd2;
`endif

    logic [1:0]    r_state;
    logic [TW-1:0] r_time;
    logic [PW-1:0] r_presc;
    logic [OW-1:0] r_bcd;
    logic          r_charging;
    logic          r_done;
    logic          r_sat;

    logic [1:0]    w_state_nx;
    logic [TW-1:0] w_time_nx;
    logic [PW-1:0] w_presc_nx;
    logic          w_done_nx;
    logic          w_sat_nx;

    logic          w_tick;
    logic          w_coin_ok;
    logic [TW-1:0] w_credit;
    logic [TW-1:0] w_base;
    logic [TW-1:0] w_sum;
    logic          w_over;
    logic [TW-1:0] w_clip;

`ifndef CHARGE_PAUSE_EN
    // Without the pause feature the Pause input is deliberately unused.
    logic w_unused_pause;
    assign w_unused_pause = Pause;
`endif

    // Convert binary seconds to {minute digits, seconds tens, seconds units}.
    function automatic logic [OW-1:0] to_bcd(input logic [TW-1:0] t);
        logic [OW-1:0] b;
        int unsigned   m;
        int unsigned   s;
        b      = '0;
        m      = 32'(t) / 60;
        s      = 32'(t) % 60;
        b[3:0] = 4'(s % 10);
        b[7:4] = 4'(s / 10);
        for (int i = 0; i < MIN_DIGITS; i++) begin
            b[8+4*i +: 4] = 4'(m % 10);
            m             = m / 10;
        end
        return b;
    endfunction

    // Decode the coin code into its credit in seconds; unknown codes count as no coin.
    always_comb begin
        w_credit  = '0;
        w_coin_ok = 1'b0;
        if (CoinValid) begin
            case (Coin)
                3'b001:  begin w_credit = TW'(30);  w_coin_ok = 1'b1; end
                3'b010:  begin w_credit = TW'(60);  w_coin_ok = 1'b1; end
                3'b100:  begin w_credit = TW'(300); w_coin_ok = 1'b1; end
                default: begin w_credit = '0;       w_coin_ok = 1'b0; end
            endcase
        end
    end

    // A tick fires on the terminal prescaler count, and only while charging.
    // Time is always nonzero in CHARGING, so the one-second decrement never wraps.
    assign w_tick = (r_state == c_CHARGING) && (r_presc == c_TERM);
    assign w_base = r_time - {{(TW-1){1'b0}}, w_tick};
    assign w_sum  = w_base + w_credit;
    assign w_over = (w_sum > c_MAX);
    assign w_clip = w_over ? c_MAX : w_sum;

    // Next-state logic. Cancel overrides everything, including a coin in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_time_nx  = r_time;
        w_presc_nx = r_presc;
        w_done_nx  = 1'b0;
        w_sat_nx   = 1'b0;
        if (Cancel) begin
            w_state_nx = c_IDLE;
            w_time_nx  = '0;
            w_presc_nx = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_coin_ok) begin
                        w_time_nx  = w_clip;
                        w_sat_nx   = w_over;
                        w_state_nx = c_CHARGING;
                        w_presc_nx = '0;
                    end
                end
                c_CHARGING: begin
                    w_presc_nx = w_tick ? '0 : r_presc + PW'(1);
                    if (w_coin_ok) begin
                        w_time_nx = w_clip;
                        w_sat_nx  = w_over;
                    end else begin
                        w_time_nx = w_base;
                    end
                    if (!w_coin_ok && (w_base == '0)) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = c_IDLE;
                        w_presc_nx = '0;
                    end
`ifdef CHARGE_PAUSE_EN
                    else if (Pause) begin
                        w_state_nx = c_PAUSED;
                    end
`endif
                end
`ifdef CHARGE_PAUSE_EN
                c_PAUSED: begin
                    // The prescaler holds so the countdown resumes mid-second.
                    if (w_coin_ok) begin
                        w_time_nx = w_clip;
                        w_sat_nx  = w_over;
                    end
                    if (!Pause) begin
                        w_state_nx = c_CHARGING;
                    end
                end
`endif
                default: begin
                    w_state_nx = c_IDLE;
                    w_time_nx  = '0;
                    w_presc_nx = '0;
                end
            endcase
        end
    end

    // State, time and registered outputs; reset discards all credit at once.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= c_IDLE;
            r_time     <= '0;
            r_presc    <= '0;
            r_bcd      <= '0;
            r_charging <= 1'b0;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_time     <= w_time_nx;
            r_presc    <= w_presc_nx;
            r_bcd      <= to_bcd(w_time_nx);
            r_charging <= (w_state_nx == c_CHARGING);
            r_done     <= w_done_nx;
            r_sat      <= w_sat_nx;
        end
    end

    assign PresentTime = r_bcd;
    assign Charging    = r_charging;
    assign Done        = r_done;
    assign Saturated   = r_sat;

endmodule
`default_nettype wire
